// File: rtl/mesi_cache_ctrl.sv
// MESI coherence controller for a direct-mapped cache with snooping and a req/gnt bus port.
// Optional hit/miss/write-back counters are compiled in when MESI_STATS_EN is defined.
module mesi_cache_ctrl #(
  parameter int IDX_W = 2,
  parameter int TAG_W = 8,
  localparam int AW = TAG_W + IDX_W,
  localparam int NUM_LINES = 1 << IDX_W
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          cpu_valid,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_ready,
  output logic          cpu_done,
  output logic          cpu_hit,
  output logic          bus_req,
  input  logic          bus_gnt,
  output logic [2:0]    bus_cmd,
  output logic [AW-1:0] bus_addr,
  input  logic          bus_shared,
  input  logic          snp_valid,
  input  logic [2:0]    snp_cmd,
  input  logic [AW-1:0] snp_addr,
  output logic          snp_flush,
  output logic [2:0]    line_state
`ifdef MESI_STATS_EN
  ,
  output logic [15:0]   stat_hit,
  output logic [15:0]   stat_miss,
  output logic [15:0]   stat_wb
`endif
);

  localparam logic [2:0] ST_I = 3'b001;
  localparam logic [2:0] ST_S = 3'b010;
  localparam logic [2:0] ST_E = 3'b011;
  localparam logic [2:0] ST_M = 3'b100;

  localparam logic [2:0] CMD_RM  = 3'b001;
  localparam logic [2:0] CMD_WM  = 3'b010;
  localparam logic [2:0] CMD_WB  = 3'b011;
  localparam logic [2:0] CMD_INV = 3'b100;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WB    = 2'd1;
  localparam logic [1:0] S_BUSOP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [NUM_LINES-1:0][2:0]       st_q, st_d;
  logic [NUM_LINES-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [1:0]    fsm_q, fsm_d;
  logic [AW-1:0] req_addr_q, req_addr_d;
  logic          req_wr_q, req_wr_d;
  logic          bus_req_q, bus_req_d;
  logic [2:0]    cmd_q, cmd_d;
  logic [AW-1:0] baddr_q, baddr_d;
  logic          issued_q, issued_d;
  logic          flush_q, flush_d;
  logic          wb_grant;

  logic [IDX_W-1:0] s_idx, c_idx, r_idx;
  logic [TAG_W-1:0] s_tag, c_tag, r_tag;

  assign s_idx = snp_addr[IDX_W-1:0];
  assign s_tag = snp_addr[AW-1:IDX_W];
  assign c_idx = cpu_addr[IDX_W-1:0];
  assign c_tag = cpu_addr[AW-1:IDX_W];
  assign r_idx = req_addr_q[IDX_W-1:0];
  assign r_tag = req_addr_q[AW-1:IDX_W];

  // Snoop update is applied to st_d first so the CPU lookup below sees post-snoop state.
  always_comb begin
    st_d       = st_q;
    tag_d      = tag_q;
    fsm_d      = fsm_q;
    req_addr_d = req_addr_q;
    req_wr_d   = req_wr_q;
    bus_req_d  = bus_req_q;
    cmd_d      = cmd_q;
    baddr_d    = baddr_q;
    issued_d   = issued_q;
    flush_d    = 1'b0;
    wb_grant   = 1'b0;

    if (snp_valid && !bus_gnt && tag_q[s_idx] == s_tag && st_q[s_idx] != ST_I) begin
      case (snp_cmd)
        CMD_RM: begin
          flush_d     = (st_q[s_idx] == ST_M);
          st_d[s_idx] = ST_S;
        end
        CMD_WM, CMD_INV: begin
          flush_d     = (st_q[s_idx] == ST_M);
          st_d[s_idx] = ST_I;
        end
        default: ;
      endcase
    end

    case (fsm_q)
      S_IDLE: begin
        if (cpu_valid) begin
          req_addr_d = cpu_addr;
          req_wr_d   = cpu_wr;
          if (tag_q[c_idx] == c_tag && st_d[c_idx] != ST_I) begin
            if (cpu_wr && st_d[c_idx] == ST_S) begin
              fsm_d     = S_BUSOP;
              bus_req_d = 1'b1;
              cmd_d     = CMD_INV;
              baddr_d   = cpu_addr;
              issued_d  = 1'b1;
            end else begin
              if (cpu_wr) st_d[c_idx] = ST_M;
              fsm_d    = S_DONE;
              issued_d = 1'b0;
            end
          end else begin
            issued_d  = 1'b1;
            bus_req_d = 1'b1;
            if (st_d[c_idx] == ST_M) begin
              fsm_d   = S_WB;
              cmd_d   = CMD_WB;
              baddr_d = {tag_q[c_idx], c_idx};
            end else begin
              fsm_d   = S_BUSOP;
              cmd_d   = cpu_wr ? CMD_WM : CMD_RM;
              baddr_d = cpu_addr;
            end
          end
        end
      end
      S_WB: begin
        // A snoop that invalidated the victim makes the write-back unnecessary.
        if (bus_gnt || st_d[r_idx] == ST_I) begin
          st_d[r_idx] = ST_I;
          wb_grant    = bus_gnt;
          fsm_d       = S_BUSOP;
          cmd_d       = req_wr_q ? CMD_WM : CMD_RM;
          baddr_d     = req_addr_q;
        end
      end
      S_BUSOP: begin
        if (bus_gnt) begin
          case (cmd_q)
            CMD_RM: begin
              tag_d[r_idx] = r_tag;
              st_d[r_idx]  = bus_shared ? ST_S : ST_E;
            end
            CMD_WM: begin
              tag_d[r_idx] = r_tag;
              st_d[r_idx]  = ST_M;
            end
            default: st_d[r_idx] = ST_M;
          endcase
          fsm_d     = S_DONE;
          bus_req_d = 1'b0;
        end else if (cmd_q == CMD_INV && st_d[r_idx] == ST_I) begin
          cmd_d = CMD_WM;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      st_q       <= {NUM_LINES{ST_I}};
      tag_q      <= '0;
      fsm_q      <= S_IDLE;
      req_addr_q <= '0;
      req_wr_q   <= 1'b0;
      bus_req_q  <= 1'b0;
      cmd_q      <= '0;
      baddr_q    <= '0;
      issued_q   <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      st_q       <= st_d;
      tag_q      <= tag_d;
      fsm_q      <= fsm_d;
      req_addr_q <= req_addr_d;
      req_wr_q   <= req_wr_d;
      bus_req_q  <= bus_req_d;
      cmd_q      <= cmd_d;
      baddr_q    <= baddr_d;
      issued_q   <= issued_d;
      flush_q    <= flush_d;
    end
  end

`ifdef MESI_STATS_EN
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      stat_hit  <= '0;
      stat_miss <= '0;
      stat_wb   <= '0;
    end else begin
      if (fsm_q == S_DONE) begin
        if (!issued_q && stat_hit != 16'hFFFF) stat_hit <= stat_hit + 16'd1;
        if (issued_q && stat_miss != 16'hFFFF) stat_miss <= stat_miss + 16'd1;
      end
      if (wb_grant && stat_wb != 16'hFFFF) stat_wb <= stat_wb + 16'd1;
    end
  end
`endif

  assign cpu_ready  = (fsm_q == S_IDLE) && !CLR;
  assign cpu_done   = (fsm_q == S_DONE);
  assign cpu_hit    = cpu_done && !issued_q;
  assign bus_req    = bus_req_q;
  assign bus_cmd    = cmd_q;
  assign bus_addr   = baddr_q;
  assign snp_flush  = flush_q;
  assign line_state = st_q[c_idx];

endmodule

// File: tb/tb_mesi_cache_ctrl.sv
// Self-checking bench for mesi_cache_ctrl: directed coherence scenarios plus
// randomized CPU traffic against a small reference model with expected-result queues.
module tb_mesi_cache_ctrl;
  localparam int IDX_W = 2;
  localparam int TAG_W = 8;
  localparam int AW = TAG_W + IDX_W;

  localparam logic [2:0] ST_I = 3'b001;
  localparam logic [2:0] ST_S = 3'b010;
  localparam logic [2:0] ST_E = 3'b011;
  localparam logic [2:0] ST_M = 3'b100;
  localparam logic [2:0] CMD_RM  = 3'b001;
  localparam logic [2:0] CMD_WM  = 3'b010;
  localparam logic [2:0] CMD_WB  = 3'b011;
  localparam logic [2:0] CMD_INV = 3'b100;

  logic          CLK = 1'b0;
  logic          CLR;
  logic          cpu_valid, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic          cpu_ready, cpu_done, cpu_hit;
  logic          bus_req, bus_gnt, bus_shared;
  logic [2:0]    bus_cmd;
  logic [AW-1:0] bus_addr;
  logic          snp_valid;
  logic [2:0]    snp_cmd;
  logic [AW-1:0] snp_addr;
  logic          snp_flush;
  logic [2:0]    line_state;
`ifdef MESI_STATS_EN
  logic [15:0]   stat_hit, stat_miss, stat_wb;
`endif

  mesi_cache_ctrl #(.IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .CLK(CLK), .CLR(CLR),
    .cpu_valid(cpu_valid), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_hit(cpu_hit),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
    .bus_shared(bus_shared),
    .snp_valid(snp_valid), .snp_cmd(snp_cmd), .snp_addr(snp_addr),
    .snp_flush(snp_flush), .line_state(line_state)
`ifdef MESI_STATS_EN
    , .stat_hit(stat_hit), .stat_miss(stat_miss), .stat_wb(stat_wb)
`endif
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard: {cpu_hit, line_state} per request and {cmd, addr} per bus op
  logic [3:0]  exp_q[$];
  logic [12:0] bus_q[$];

  logic [2:0]       m_st [4];
  logic [TAG_W-1:0] m_tag[4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_st[i]  = ST_I;
      m_tag[i] = '0;
    end
  endtask

  task automatic sb_done();
    logic [3:0] e;
    if (exp_q.size() == 0) check("sb_underflow", 1, 0);
    else begin
      e = exp_q.pop_front();
      check("cpu_hit", cpu_hit, e[3]);
      check("line_state", line_state, e[2:0]);
    end
  endtask

  // Drive one CPU request, act as bus arbiter (grant after dly waits), score completion.
  task automatic run_req(input logic [AW-1:0] addr, input logic wr, input int dly, input logic shared);
    logic [IDX_W-1:0] ix;
    logic [TAG_W-1:0] t;
    logic             hit, ehit;
    int               n, w;
    bit               done;
    logic [12:0]      be;
    ix = addr[IDX_W-1:0];
    t  = addr[AW-1:IDX_W];
    hit = (m_tag[ix] == t) && (m_st[ix] != ST_I);
    ehit = 1'b1;
    if (hit) begin
      if (wr) begin
        if (m_st[ix] == ST_S) begin
          bus_q.push_back({CMD_INV, addr});
          ehit = 1'b0;
        end
        m_st[ix] = ST_M;
      end
    end else begin
      ehit = 1'b0;
      if (m_st[ix] == ST_M) bus_q.push_back({CMD_WB, m_tag[ix], ix});
      bus_q.push_back({wr ? CMD_WM : CMD_RM, addr});
      m_st[ix]  = wr ? ST_M : (shared ? ST_S : ST_E);
      m_tag[ix] = t;
    end
    exp_q.push_back({ehit, m_st[ix]});

    @(negedge CLK);
    check("cpu_ready", cpu_ready, 1);
    cpu_valid = 1'b1; cpu_wr = wr; cpu_addr = addr;
    @(negedge CLK);
    cpu_valid = 1'b0;
    n = 1; w = 0; done = 0;
    while (!done && n < 60) begin
      bus_gnt = 1'b0;
      if (cpu_done) begin
        sb_done();
        if (ehit) check("hit_latency", n, 1);
        done = 1;
      end else if (bus_req) begin
        w++;
        if (w > dly) begin
          if (bus_q.size() == 0) check("bus_unexpected", {bus_cmd, bus_addr}, 0);
          else begin
            be = bus_q.pop_front();
            check("bus_op", {bus_cmd, bus_addr}, be);
          end
          bus_gnt = 1'b1; bus_shared = shared; w = 0;
        end
      end
      if (!done) begin
        @(negedge CLK);
        n++;
      end
    end
    bus_gnt = 1'b0; bus_shared = 1'b0;
    if (!done) check("done_timeout", 0, 1);
    check("bus_ops_left", bus_q.size(), 0);
    bus_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ra;
    CLR = 1'b1; cpu_valid = 0; cpu_wr = 0; cpu_addr = '0;
    bus_gnt = 0; bus_shared = 0; snp_valid = 0; snp_cmd = '0; snp_addr = '0;
    model_reset();
    repeat (3) @(negedge CLK);
    check("rst_ready", cpu_ready, 0);
    check("rst_done", cpu_done, 0);
    check("rst_hit", cpu_hit, 0);
    check("rst_req", bus_req, 0);
    check("rst_cmd", bus_cmd, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_flush", snp_flush, 0);
    check("rst_state", line_state, ST_I);
    CLR = 1'b0;

    // 1: read miss, exclusive fill; 2: silent E->M write hit; 3: victim write-back then shared fill
    run_req(10'h105, 1'b0, 2, 1'b0);
    run_req(10'h105, 1'b1, 0, 1'b0);
    run_req(10'h205, 1'b0, 1, 1'b1);

    // 4: write hit on S; snoop WM before grant turns INV into WM
    exp_q.push_back({1'b0, ST_M});
    @(negedge CLK);
    cpu_valid = 1; cpu_wr = 1; cpu_addr = 10'h205;
    @(negedge CLK);
    cpu_valid = 0;
    check("t4_inv", {bus_req, bus_cmd, bus_addr}, {1'b1, CMD_INV, 10'h205});
    snp_valid = 1; snp_cmd = CMD_WM; snp_addr = 10'h205;
    @(negedge CLK);
    snp_valid = 0;
    check("t4_wm", {bus_req, bus_cmd, bus_addr}, {1'b1, CMD_WM, 10'h205});
    check("t4_flush", snp_flush, 0);
    check("t4_state_i", line_state, ST_I);
    bus_gnt = 1;
    @(negedge CLK);
    bus_gnt = 0;
    check("t4_done", cpu_done, 1);
    if (cpu_done) sb_done();
    @(negedge CLK);
    check("t4_req_drop", bus_req, 0);
    m_st[1] = ST_M; m_tag[1] = 8'h81;

    // 5: snoops on an M line: mismatched tag, RM (flush, ->S), INV (->I, no flush)
    snp_valid = 1; snp_cmd = CMD_RM; snp_addr = 10'h305;
    @(negedge CLK);
    check("t5_miss_flush", snp_flush, 0);
    check("t5_miss_state", line_state, ST_M);
    snp_addr = 10'h205;
    @(negedge CLK);
    check("t5_rm_flush", snp_flush, 1);
    check("t5_rm_state", line_state, ST_S);
    snp_cmd = CMD_INV;
    @(negedge CLK);
    snp_valid = 0;
    check("t5_inv_flush", snp_flush, 0);
    check("t5_inv_state", line_state, ST_I);
    m_st[1] = ST_I;

    // randomized traffic against the model
    for (int k = 0; k < 24; k++) begin
      ra = {8'($urandom_range(1, 3)), 2'($urandom_range(0, 3))};
      run_req(ra, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // 6: reset while a bus request is pending
    run_req(10'h0C0, 1'b0, 0, 1'b0);
    @(negedge CLK);
    cpu_valid = 1; cpu_wr = 0; cpu_addr = 10'h10A;
    @(negedge CLK);
    cpu_valid = 0;
    check("t6_req_pending", bus_req, 1);
    CLR = 1;
    #1;
    check("t6_req_clr", bus_req, 0);
    for (int i = 0; i < 4; i++) begin
      cpu_addr = 10'(i);
      #1;
      check("t6_line_i", line_state, ST_I);
    end
    @(negedge CLK);
    CLR = 0;
    model_reset();
    #1;
    check("t6_ready", cpu_ready, 1);
    repeat (2) @(negedge CLK);
    check("t6_no_replay", bus_req, 0);
    check("t6_no_done", cpu_done, 0);
    run_req(10'h0C0, 1'b0, 1, 1'b1);

    check("sb_leftover", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
